// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the data-memory SRAM port between the MEM stage (fixed priority) and a
// valid/ready debug port. The optional debug starvation guard is enabled by defining DM_ARB_STARVE_GUARD_EN.

module dm_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int READ_LAT     = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cpu_req_valid,
    input  logic [DATA_W/8-1:0]   cpu_req_we,
    input  logic [ADDR_W-1:0]     cpu_req_addr,
    input  logic [DATA_W-1:0]     cpu_req_wdata,
    output logic                  cpu_stall,
    output logic                  cpu_rsp_valid,
    output logic [DATA_W-1:0]     cpu_rsp_data,
    input  logic                  dbg_req_valid,
    output logic                  dbg_req_ready,
    input  logic [DATA_W/8-1:0]   dbg_req_we,
    input  logic [ADDR_W-1:0]     dbg_req_addr,
    input  logic [DATA_W-1:0]     dbg_req_wdata,
    output logic                  dbg_rsp_valid,
    output logic [DATA_W-1:0]     dbg_rsp_data,
    output logic [DATA_W/8-1:0]   sram_w_en,
    output logic [ADDR_W-1:0]     sram_address,
    output logic [DATA_W-1:0]     sram_write_data,
    input  logic [DATA_W-1:0]     sram_read_data
);

    localparam int BE_W = DATA_W / 8;

    if (READ_LAT < 1 || READ_LAT > 2) begin : g_lat_check
        $error("dm_port_arbiter: READ_LAT must be 1 or 2");
    end
    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("dm_port_arbiter: STARVE_LIMIT must be at least 1");
    end

    logic                cpu_grant_s;
    logic                dbg_grant_s;
    logic                force_s;
    logic                rd_push_s;
    logic                tail_valid_s;
    logic                tail_owner_s;
    logic [READ_LAT-1:0] rsp_valid_r;
    logic [READ_LAT-1:0] rsp_owner_r;

`ifdef DM_ARB_STARVE_GUARD_EN
    typedef enum logic [0:0] {
        ARB_NORM  = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_e;

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_r;
    logic [CNT_W-1:0] starve_cnt_r;
    logic [CNT_W-1:0] starve_cnt_s;

    // Next starve count: grows while dbg waits unserved, saturates at the limit
    always_comb begin
        starve_cnt_s = starve_cnt_r;
        if (!dbg_req_valid || dbg_grant_s) begin
            starve_cnt_s = {CNT_W{1'b0}};
        end else if (starve_cnt_r == CNT_MAX) begin
            starve_cnt_s = CNT_MAX;
        end else begin
            starve_cnt_s = starve_cnt_r + CNT_W'(1);
        end
    end

    // Arbitration FSM: a single forced dbg slot once the starve count hits the limit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ARB_NORM;
            starve_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ARB_NORM: begin
                    starve_cnt_r <= starve_cnt_s;
                    if (starve_cnt_s == CNT_MAX) begin
                        state_r <= ARB_FORCE;
                    end else begin
                        state_r <= ARB_NORM;
                    end
                end
                ARB_FORCE: begin
                    state_r      <= ARB_NORM;
                    starve_cnt_r <= {CNT_W{1'b0}};
                end
                default: begin
                    state_r      <= ARB_NORM;
                    starve_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign force_s = (state_r == ARB_FORCE);
`else
    assign force_s = 1'b0;
`endif

    // Same-cycle grant; a forced slot overrides CPU priority only if dbg is still requesting
    always_comb begin
        cpu_grant_s = 1'b0;
        dbg_grant_s = 1'b0;
        if (!reset_n) begin
            cpu_grant_s = 1'b0;
            dbg_grant_s = 1'b0;
        end else if (force_s && dbg_req_valid) begin
            dbg_grant_s = 1'b1;
        end else if (cpu_req_valid) begin
            cpu_grant_s = 1'b1;
        end else if (dbg_req_valid) begin
            dbg_grant_s = 1'b1;
        end else begin
            cpu_grant_s = 1'b0;
            dbg_grant_s = 1'b0;
        end
    end

    // SRAM port mux; idle port is driven to all zeros
    always_comb begin
        sram_w_en       = {BE_W{1'b0}};
        sram_address    = {ADDR_W{1'b0}};
        sram_write_data = {DATA_W{1'b0}};
        case ({cpu_grant_s, dbg_grant_s})
            2'b10: begin
                sram_w_en       = cpu_req_we;
                sram_address    = cpu_req_addr;
                sram_write_data = cpu_req_wdata;
            end
            2'b01: begin
                sram_w_en       = dbg_req_we;
                sram_address    = dbg_req_addr;
                sram_write_data = dbg_req_wdata;
            end
            default: begin
                sram_w_en       = {BE_W{1'b0}};
                sram_address    = {ADDR_W{1'b0}};
                sram_write_data = {DATA_W{1'b0}};
            end
        endcase
    end

    assign cpu_stall     = reset_n & cpu_req_valid & ~cpu_grant_s;
    assign dbg_req_ready = dbg_grant_s;

    assign rd_push_s = (cpu_grant_s && (cpu_req_we == {BE_W{1'b0}})) ||
                       (dbg_grant_s && (dbg_req_we == {BE_W{1'b0}}));

    // Response tag pipe matching the SRAM read latency; owner 1 marks a dbg read
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_r <= {READ_LAT{1'b0}};
            rsp_owner_r <= {READ_LAT{1'b0}};
        end else begin
            rsp_valid_r[0] <= rd_push_s;
            rsp_owner_r[0] <= dbg_grant_s;
            for (int i = 1; i < READ_LAT; i++) begin
                rsp_valid_r[i] <= rsp_valid_r[i-1];
                rsp_owner_r[i] <= rsp_owner_r[i-1];
            end
        end
    end

    assign tail_valid_s  = rsp_valid_r[READ_LAT-1];
    assign tail_owner_s  = rsp_owner_r[READ_LAT-1];
    assign cpu_rsp_valid = tail_valid_s & ~tail_owner_s;
    assign dbg_rsp_valid = tail_valid_s & tail_owner_s;
    assign cpu_rsp_data  = cpu_rsp_valid ? sram_read_data : {DATA_W{1'b0}};
    assign dbg_rsp_data  = dbg_rsp_valid ? sram_read_data : {DATA_W{1'b0}};

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: two instances (READ_LAT 1 and 2) share directed stimulus;
// responses are checked against a scoreboard queue per instance.

module tb_dm_port_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req_valid = 1'b0;
    logic [3:0]  cpu_req_we = 4'h0;
    logic [15:0] cpu_req_addr = 16'h0;
    logic [31:0] cpu_req_wdata = 32'h0;
    logic        dbg_req_valid = 1'b0;
    logic [3:0]  dbg_req_we = 4'h0;
    logic [15:0] dbg_req_addr = 16'h0;
    logic [31:0] dbg_req_wdata = 32'h0;

    logic        cpu_stall_1, cpu_rsp_valid_1, dbg_req_ready_1, dbg_rsp_valid_1;
    logic [31:0] cpu_rsp_data_1, dbg_rsp_data_1, sram_write_data_1, sram_read_data_1;
    logic [3:0]  sram_w_en_1;
    logic [15:0] sram_address_1;
    logic        cpu_stall_2, cpu_rsp_valid_2, dbg_req_ready_2, dbg_rsp_valid_2;
    logic [31:0] cpu_rsp_data_2, dbg_rsp_data_2, sram_write_data_2, sram_read_data_2;
    logic [3:0]  sram_w_en_2;
    logic [15:0] sram_address_2;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    dm_port_arbiter #(.ADDR_W(16), .DATA_W(32), .READ_LAT(1), .STARVE_LIMIT(8)) u_dut1 (
        .clock(clock), .reset_n(reset_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
        .cpu_req_wdata(cpu_req_wdata), .cpu_stall(cpu_stall_1), .cpu_rsp_valid(cpu_rsp_valid_1),
        .cpu_rsp_data(cpu_rsp_data_1), .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready_1),
        .dbg_req_we(dbg_req_we), .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
        .dbg_rsp_valid(dbg_rsp_valid_1), .dbg_rsp_data(dbg_rsp_data_1), .sram_w_en(sram_w_en_1),
        .sram_address(sram_address_1), .sram_write_data(sram_write_data_1),
        .sram_read_data(sram_read_data_1)
    );

    dm_port_arbiter #(.ADDR_W(16), .DATA_W(32), .READ_LAT(2), .STARVE_LIMIT(8)) u_dut2 (
        .clock(clock), .reset_n(reset_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
        .cpu_req_wdata(cpu_req_wdata), .cpu_stall(cpu_stall_2), .cpu_rsp_valid(cpu_rsp_valid_2),
        .cpu_rsp_data(cpu_rsp_data_2), .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready_2),
        .dbg_req_we(dbg_req_we), .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
        .dbg_rsp_valid(dbg_rsp_valid_2), .dbg_rsp_data(dbg_rsp_data_2), .sram_w_en(sram_w_en_2),
        .sram_address(sram_address_2), .sram_write_data(sram_write_data_2),
        .sram_read_data(sram_read_data_2)
    );

    // SRAM models: registered read, byte-enable write, preloaded on the first clock
    logic [31:0] mem1 [0:255];
    logic [31:0] mem2 [0:255];
    logic [31:0] rd1_a, rd2_a, rd2_b;
    logic        init_done = 1'b0;

    always @(posedge clock) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 32'h0;
                mem2[i] <= 32'h0;
            end
            mem1[8'h10] <= 32'hDEADBEEF;  mem2[8'h10] <= 32'hDEADBEEF;
            mem1[8'h20] <= 32'hA5A50001;  mem2[8'h20] <= 32'hA5A50001;
            mem1[8'h21] <= 32'h0BADF00D;  mem2[8'h21] <= 32'h0BADF00D;
            mem1[8'h30] <= 32'h11112222;  mem2[8'h30] <= 32'h11112222;
            init_done <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (sram_w_en_1[b]) mem1[sram_address_1[7:0]][b*8 +: 8] <= sram_write_data_1[b*8 +: 8];
                if (sram_w_en_2[b]) mem2[sram_address_2[7:0]][b*8 +: 8] <= sram_write_data_2[b*8 +: 8];
            end
        end
        rd1_a <= mem1[sram_address_1[7:0]];
        rd2_a <= mem2[sram_address_2[7:0]];
        rd2_b <= rd2_a;
    end

    assign sram_read_data_1 = rd1_a;
    assign sram_read_data_2 = rd2_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Both instances must show the same grant view: {stall, ready, we, addr}
    task automatic chk_grant(input string name, input logic stall, input logic ready,
                             input logic [3:0] we, input logic [15:0] addr);
        logic [31:0] e;
        e = {10'b0, stall, ready, we, addr};
        chk({name, "_lat1"}, {10'b0, cpu_stall_1, dbg_req_ready_1, sram_w_en_1, sram_address_1}, e);
        chk({name, "_lat2"}, {10'b0, cpu_stall_2, dbg_req_ready_2, sram_w_en_2, sram_address_2}, e);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_grant1"}, {10'b0, cpu_stall_1, dbg_req_ready_1, sram_w_en_1, sram_address_1}, 32'h0);
        chk({name, "_grant2"}, {10'b0, cpu_stall_2, dbg_req_ready_2, sram_w_en_2, sram_address_2}, 32'h0);
        chk({name, "_wdata"}, sram_write_data_1 | sram_write_data_2, 32'h0);
        chk({name, "_rspv"}, {28'h0, cpu_rsp_valid_1, dbg_rsp_valid_1, cpu_rsp_valid_2, dbg_rsp_valid_2}, 32'h0);
        chk({name, "_rspd"}, cpu_rsp_data_1 | dbg_rsp_data_1 | cpu_rsp_data_2 | dbg_rsp_data_2, 32'h0);
    endtask

    task automatic push_exp(input logic owner, input logic [31:0] data, input bit use1, input bit use2);
        if (use1) q1.push_back('{owner: owner, data: data, due: cyc + 1});
        if (use2) q2.push_back('{owner: owner, data: data, due: cyc + 2});
    endtask

    task automatic apply(input logic cv, input logic [3:0] cwe, input logic [15:0] ca, input logic [31:0] cd,
                         input logic dv, input logic [3:0] dwe, input logic [15:0] da, input logic [31:0] dd);
        @(posedge clock);
        #1;
        cpu_req_valid = cv;  cpu_req_we = cwe;  cpu_req_addr = ca;  cpu_req_wdata = cd;
        dbg_req_valid = dv;  dbg_req_we = dwe;  dbg_req_addr = da;  dbg_req_wdata = dd;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 4'h0, 16'h0, 32'h0);
    endtask

    task automatic mon(input int inst, input logic cv, input logic dv,
                       input logic [31:0] cd, input logic [31:0] dd);
        exp_t        e;
        logic [31:0] got;
        bit          empty;
        if (cv || dv) begin
            n_vec++;
            got   = dv ? dd : cd;
            empty = (inst == 1) ? (q1.size() == 0) : (q2.size() == 0);
            if (empty) begin
                n_err++;
                $display("FAIL rsp_unexpected_lat%0d: got cpu_v=%b dbg_v=%b data %h at cycle %0d, required no response",
                         inst, cv, dv, got, cyc);
            end else begin
                if (inst == 1) e = q1.pop_front();
                else           e = q2.pop_front();
                if ((cv && dv) || (dv !== e.owner) || (got !== e.data) || (cyc != e.due)) begin
                    n_err++;
                    $display("FAIL rsp_lat%0d: got cpu_v=%b dbg_v=%b data %h cycle %0d, required owner=%s data %h cycle %0d",
                             inst, cv, dv, got, cyc, e.owner ? "dbg" : "cpu", e.data, e.due);
                end
            end
        end
    endtask

    // Response monitor, decoupled from stimulus
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                mon(1, cpu_rsp_valid_1, dbg_rsp_valid_1, cpu_rsp_data_1, dbg_rsp_data_1);
                mon(2, cpu_rsp_valid_2, dbg_rsp_valid_2, cpu_rsp_data_2, dbg_rsp_data_2);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clock);
        chk_zero("reset_state");
        @(posedge clock);
        #1 reset_n = 1'b1;

        // CPU read
        apply(1'b1, 4'h0, 16'h0010, 32'h0, 1'b0, 4'h0, 16'h0, 32'h0);
        chk_grant("cpu_read", 1'b0, 1'b0, 4'h0, 16'h0010);
        push_exp(1'b0, 32'hDEADBEEF, 1'b1, 1'b1);
        idle(1);
        chk_grant("idle_port", 1'b0, 1'b0, 4'h0, 16'h0000);
        idle(1);

        // Debug write then debug read-back
        apply(1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 4'hF, 16'h0004, 32'h12345678);
        chk_grant("dbg_write", 1'b0, 1'b1, 4'hF, 16'h0004);
        chk("dbg_wdata", sram_write_data_1, 32'h12345678);
        apply(1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 4'h0, 16'h0004, 32'h0);
        chk_grant("dbg_read", 1'b0, 1'b1, 4'h0, 16'h0004);
        push_exp(1'b1, 32'h12345678, 1'b1, 1'b1);

        // Simultaneous requests: CPU wins, dbg served next
        apply(1'b1, 4'h0, 16'h0020, 32'h0, 1'b1, 4'h0, 16'h0021, 32'h0);
        chk_grant("both_valid", 1'b0, 1'b0, 4'h0, 16'h0020);
        push_exp(1'b0, 32'hA5A50001, 1'b1, 1'b1);
        apply(1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 4'h0, 16'h0021, 32'h0);
        chk_grant("dbg_after_cpu", 1'b0, 1'b1, 4'h0, 16'h0021);
        push_exp(1'b1, 32'h0BADF00D, 1'b1, 1'b1);

        // Partial byte-enable write then read
        apply(1'b1, 4'h3, 16'h0030, 32'hFFFF9999, 1'b0, 4'h0, 16'h0, 32'h0);
        chk_grant("be_write", 1'b0, 1'b0, 4'h3, 16'h0030);
        apply(1'b1, 4'h0, 16'h0030, 32'h0, 1'b0, 4'h0, 16'h0, 32'h0);
        push_exp(1'b0, 32'h11119999, 1'b1, 1'b1);

        // Back-to-back alternating owners with interleaved writes
        apply(1'b1, 4'h0, 16'h0010, 32'h0, 1'b0, 4'h0, 16'h0, 32'h0);
        push_exp(1'b0, 32'hDEADBEEF, 1'b1, 1'b1);
        apply(1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 4'h0, 16'h0030, 32'h0);
        push_exp(1'b1, 32'h11119999, 1'b1, 1'b1);
        apply(1'b1, 4'hF, 16'h0031, 32'hCAFEBABE, 1'b0, 4'h0, 16'h0, 32'h0);
        apply(1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 4'h0, 16'h0031, 32'h0);
        push_exp(1'b1, 32'hCAFEBABE, 1'b1, 1'b1);
        apply(1'b1, 4'h0, 16'h0004, 32'h0, 1'b0, 4'h0, 16'h0, 32'h0);
        push_exp(1'b0, 32'h12345678, 1'b1, 1'b1);
        apply(1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 4'h4, 16'h0005, 32'h00AB0000);
        chk_grant("dbg_be_write", 1'b0, 1'b1, 4'h4, 16'h0005);
        apply(1'b1, 4'h0, 16'h0005, 32'h0, 1'b0, 4'h0, 16'h0, 32'h0);
        push_exp(1'b0, 32'h00AB0000, 1'b1, 1'b1);
        idle(3);

        // Starvation: CPU writes every cycle while dbg waits
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 4'hF, 16'h0040, i, 1'b1, 4'h0, 16'h0010, 32'h0);
            chk_grant("starve", 1'b0, 1'b0, 4'hF, 16'h0040);
        end
        apply(1'b1, 4'hF, 16'h0040, 32'h8, 1'b1, 4'h0, 16'h0010, 32'h0);
`ifdef DM_ARB_STARVE_GUARD_EN
        chk_grant("starve_force", 1'b1, 1'b1, 4'h0, 16'h0010);
        push_exp(1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
`else
        chk_grant("starve_noguard", 1'b0, 1'b0, 4'hF, 16'h0040);
`endif
        apply(1'b1, 4'hF, 16'h0040, 32'h9, 1'b1, 4'h0, 16'h0010, 32'h0);
        chk_grant("starve_cpu_back", 1'b0, 1'b0, 4'hF, 16'h0040);
        idle(3);

        // Reset while a read is being granted: dropped, outputs held at zero
        apply(1'b1, 4'h0, 16'h0010, 32'h0, 1'b0, 4'h0, 16'h0, 32'h0);
        #2 reset_n = 1'b0;
        #1 chk_zero("rst_mid_grant");
        apply(1'b1, 4'hF, 16'h0050, 32'h55AA55AA, 1'b1, 4'h0, 16'h0011, 32'h0);
        chk_zero("rst_held");
        idle(1);
        #2 reset_n = 1'b1;
        idle(3);

        // Reset with a read in flight in the latency-2 pipe
        apply(1'b1, 4'h0, 16'h0010, 32'h0, 1'b0, 4'h0, 16'h0, 32'h0);
        push_exp(1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
        idle(1);
        #2 reset_n = 1'b0;
        #1 chk_zero("rst_inflight");
        idle(1);
        #2 reset_n = 1'b1;
        idle(4);

        chk("q_lat1_drained", q1.size(), 32'h0);
        chk("q_lat2_drained", q2.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
